// File: rtl/alu_acc_pkg.sv
// alu_acc shared types: width, flag indices, op enum.
// Optional feature macro: ALU_ACC_MULDIV_EN.
package alu_acc_pkg;

  localparam int WIDTH = 16;

  localparam int ZF_BIT = 3;
  localparam int CF_BIT = 2;
  localparam int OF_BIT = 1;
  localparam int SF_BIT = 0;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_CLR,
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV,
    OP_SHL,
    OP_SHR,
    OP_AND,
    OP_OR,
    OP_NOT
  } op_e;

endpackage

// File: rtl/alu_acc_core.sv
// alu_acc combinational datapath: result and next flags.
// Macro ALU_ACC_MULDIV_EN enables multiplier and divider.
module alu_acc_core
  import alu_acc_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  op_e          i_op,
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_br,
  output logic [W-1:0] o_res,
  output logic [3:0]   o_flags
);

  logic [W:0]     w_add;
  logic [W:0]     w_sub;
  logic [W:0]     w_shl;
  logic [W:0]     w_shr;
  logic [3:0]     w_sh;
  logic           w_cf;
  logic           w_of;

  assign w_sh  = i_br[3:0];
  assign w_add = {1'b0, i_acc} + {1'b0, i_br};
  assign w_sub = {1'b0, i_acc} - {1'b0, i_br};
  assign w_shl = {1'b0, i_acc} << w_sh;
  assign w_shr = {i_acc, 1'b0} >> w_sh;

`ifdef ALU_ACC_MULDIV_EN
  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quo;
  logic           w_dz;

  assign w_prod = {{W{1'b0}}, i_acc} * {{W{1'b0}}, i_br};
  assign w_dz   = (i_br == '0);
  assign w_quo  = w_dz ? i_acc : i_acc / i_br;
`endif

  // Select result and carry/overflow for the decoded op.
  always_comb begin
    o_res = i_acc;
    w_cf  = 1'b0;
    w_of  = 1'b0;
    unique case (i_op)
      OP_CLR: o_res = '0;
      OP_ADD: begin
        o_res = w_add[W-1:0];
        w_cf  = w_add[W];
        w_of  = (i_acc[W-1] == i_br[W-1]) &&
                (w_add[W-1] != i_acc[W-1]);
      end
      OP_SUB: begin
        o_res = w_sub[W-1:0];
        w_cf  = w_sub[W];
        w_of  = (i_acc[W-1] != i_br[W-1]) &&
                (w_sub[W-1] != i_acc[W-1]);
      end
`ifdef ALU_ACC_MULDIV_EN
      OP_MUL: begin
        o_res = w_prod[W-1:0];
        w_cf  = (w_prod[2*W-1:W] != '0);
        w_of  = w_cf;
      end
      OP_DIV: begin
        o_res = w_quo;
        w_of  = w_dz;
      end
`endif
      OP_SHL: begin
        o_res = w_shl[W-1:0];
        w_cf  = w_shl[W];
      end
      OP_SHR: begin
        o_res = w_shr[W:1];
        w_cf  = w_shr[0];
      end
      OP_AND: o_res = i_acc & i_br;
      OP_OR:  o_res = i_acc | i_br;
      OP_NOT: o_res = ~i_br;
      default: o_res = i_acc;
    endcase
  end

  // Pack the flag vector.
  always_comb begin
    o_flags         = '0;
    o_flags[ZF_BIT] = (o_res == '0);
    o_flags[CF_BIT] = w_cf;
    o_flags[OF_BIT] = w_of;
    o_flags[SF_BIT] = o_res[W-1];
  end

endmodule

// File: rtl/alu_acc.sv
// alu_acc top: priority encoder plus ACC/flag registers.
// Macro ALU_ACC_MULDIV_EN enables C15/C16.
module alu_acc
  import alu_acc_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         C8,
  input  logic         C9,
  input  logic         C13,
  input  logic         C15,
  input  logic         C16,
  input  logic         C17,
  input  logic         C18,
  input  logic         C19,
  input  logic         C20,
  input  logic         C21,
  input  logic [W-1:0] BR_in,
  output logic [W-1:0] ACC_out,
  output logic [3:0]   ALUflags
);

  op_e          w_op;
  logic         w_en;
  logic [W-1:0] w_res;
  logic [3:0]   w_flags;
  logic [W-1:0] r_acc;
  logic [3:0]   r_flags;

  // Lowest-numbered active control line wins.
  always_comb begin
    w_op = OP_NONE;
    priority case (1'b1)
      C8:  w_op = OP_CLR;
      C9:  w_op = OP_ADD;
      C13: w_op = OP_SUB;
      C15: w_op = OP_MUL;
      C16: w_op = OP_DIV;
      C17: w_op = OP_SHL;
      C18: w_op = OP_SHR;
      C19: w_op = OP_AND;
      C20: w_op = OP_OR;
      C21: w_op = OP_NOT;
      default: w_op = OP_NONE;
    endcase
  end

`ifdef ALU_ACC_MULDIV_EN
  assign w_en = (w_op != OP_NONE);
`else
  // MUL/DIV keep their slot but write nothing.
  assign w_en = (w_op != OP_NONE) &&
                (w_op != OP_MUL) &&
                (w_op != OP_DIV);
`endif

  alu_acc_core #(.W(W)) u_core (
    .i_op    (w_op),
    .i_acc   (r_acc),
    .i_br    (BR_in),
    .o_res   (w_res),
    .o_flags (w_flags)
  );

  // Accumulator and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_flags <= '0;
    end else if (w_en) begin
      r_acc   <= w_res;
      r_flags <= w_flags;
    end
  end

  assign ACC_out  = r_acc;
  assign ALUflags = r_flags;

endmodule

// File: tb/tb_alu_acc.sv
// alu_acc scoreboard bench: directed vectors, queued expectations.
// Expectations track ALU_ACC_MULDIV_EN.
module tb_alu_acc;

  logic        clk;
  logic        rst;
  logic [9:0]  ctl;
  logic [15:0] br;
  logic [15:0] acc;
  logic [3:0]  flg;

  // ctl bit 9 = C8 ... bit 0 = C21
  localparam logic [9:0] K8  = 10'b1000000000;
  localparam logic [9:0] K9  = 10'b0100000000;
  localparam logic [9:0] K13 = 10'b0010000000;
  localparam logic [9:0] K15 = 10'b0001000000;
  localparam logic [9:0] K16 = 10'b0000100000;
  localparam logic [9:0] K17 = 10'b0000010000;
  localparam logic [9:0] K18 = 10'b0000001000;
  localparam logic [9:0] K19 = 10'b0000000100;
  localparam logic [9:0] K20 = 10'b0000000010;
  localparam logic [9:0] K21 = 10'b0000000001;
  localparam logic [9:0] KN  = 10'b0000000000;

  typedef struct {
    logic [15:0] acc;
    logic [3:0]  flg;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;

  alu_acc dut (
    .clk      (clk),
    .rst      (rst),
    .C8       (ctl[9]),
    .C9       (ctl[8]),
    .C13      (ctl[7]),
    .C15      (ctl[6]),
    .C16      (ctl[5]),
    .C17      (ctl[4]),
    .C18      (ctl[3]),
    .C19      (ctl[2]),
    .C20      (ctl[1]),
    .C21      (ctl[0]),
    .BR_in    (br),
    .ACC_out  (acc),
    .ALUflags (flg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic r, input logic [9:0] c,
                       input logic [15:0] b,
                       input logic [15:0] ea,
                       input logic [3:0] ef,
                       input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    ctl = c;
    br  = b;
    e.acc  = ea;
    e.flg  = ef;
    e.name = nm;
    q.push_back(e);
  endtask

  // Monitor: one registered result per edge after issue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (acc !== e.acc || flg !== e.flg) begin
          n_bad++;
          $display("FAIL %s: got acc=%h flags=%b want acc=%h flags=%b",
                   e.name, acc, flg, e.acc, e.flg);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    ctl = KN;
    br  = '0;
    issue(1, KN,  16'h0000, 16'h0000, 4'b0000, "reset");
    issue(0, K8,  16'h0000, 16'h0000, 4'b1000, "clear");
    issue(0, K9,  16'h1234, 16'h1234, 4'b0000, "add");
    issue(0, K13, 16'h0033, 16'h1201, 4'b0000, "sub");
`ifdef ALU_ACC_MULDIV_EN
    issue(0, K15, 16'h0003, 16'h3603, 4'b0000, "mul");
    issue(0, K16, 16'h0002, 16'h1B01, 4'b0000, "div");
    issue(0, K17, 16'h0002, 16'h6C04, 4'b0000, "shl");
    issue(0, K18, 16'h0001, 16'h3602, 4'b0000, "shr");
`else
    issue(0, K15, 16'h0003, 16'h1201, 4'b0000, "mul_noop");
    issue(0, K16, 16'h0002, 16'h1201, 4'b0000, "div_noop");
    issue(0, K17, 16'h0002, 16'h4804, 4'b0000, "shl");
    issue(0, K18, 16'h0001, 16'h2402, 4'b0000, "shr");
    issue(0, K8,  16'h0000, 16'h0000, 4'b1000, "clr_re");
    issue(0, K9,  16'h3602, 16'h3602, 4'b0000, "add_re");
`endif
    issue(0, K19, 16'hFF00, 16'h3600, 4'b0000, "and");
    issue(0, K20, 16'h00FF, 16'h36FF, 4'b0000, "or");
    issue(0, K21, 16'hAAAA, 16'h5555, 4'b0000, "not");
    issue(0, K8,  16'h0000, 16'h0000, 4'b1000, "ov_clr");
    issue(0, K9,  16'h7FFF, 16'h7FFF, 4'b0000, "ov_add1");
    issue(0, K9,  16'h0001, 16'h8000, 4'b0011, "ov_add2");
    issue(0, K8,  16'h0000, 16'h0000, 4'b1000, "dz_clr");
    issue(0, K9,  16'h0005, 16'h0005, 4'b0000, "dz_add");
`ifdef ALU_ACC_MULDIV_EN
    issue(0, K16, 16'h0000, 16'h0005, 4'b0010, "div_zero");
`else
    issue(0, K16, 16'h0000, 16'h0005, 4'b0000, "div_zero_noop");
`endif
    issue(0, K8|K9, 16'h0042, 16'h0000, 4'b1000, "prio_c8");
    issue(0, KN,  16'h0042, 16'h0000, 4'b1000, "hold");
    issue(0, K9,  16'h0042, 16'h0042, 4'b0000, "add42");
    issue(0, K15|K17, 16'h0001, 16'h0042, 4'b0000, "prio_c15");
    issue(0, K13, 16'h0043, 16'hFFFF, 4'b0101, "borrow");
    issue(0, K17, 16'h0004, 16'hFFF0, 4'b0101, "shl_cf");
    issue(0, K18, 16'h0000, 16'hFFF0, 4'b0001, "shr_zero");
    issue(0, K9,  16'h0010, 16'h0000, 4'b1100, "carry");
    issue(0, K9,  16'h0123, 16'h0123, 4'b0000, "add_pre");
    issue(1, K9,  16'h0001, 16'h0000, 4'b0000, "rst_c9");
    @(negedge clk);
    rst = 1'b0;
    ctl = KN;
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_acc.md
# alu_acc

Single-cycle accumulator ALU for the BitCruncher datapath. It holds a 16-bit accumulator (ACC) that is updated from itself and the buffer-register operand (BR_in) under one-hot microcode control lines C8–C21 from the control unit. It also produces registered status flags for the sequencer's conditional branches.

## Interface
- WIDTH, 16: datapath width. The shift amount is taken from BR_in[3:0].
- clk  in  1: rising-edge clock.
- rst  in  1: reset. Synchronous, active-high.
- C8  in  1: clear. ACC ← 0.
- C9  in  1: add. ACC ← ACC + BR_in.
- C13  in  1: subtract. ACC ← ACC − BR_in.
- C15  in  1: multiply. ACC ← low 16 bits of ACC × BR_in (unsigned).
- C16  in  1: divide. ACC ← ACC / BR_in (unsigned quotient).
- C17  in  1: shift left. ACC ← ACC << BR_in[3:0].
- C18  in  1: logical shift right. ACC ← ACC >> BR_in[3:0].
- C19  in  1: AND. ACC ← ACC & BR_in.
- C20  in  1: OR. ACC ← ACC | BR_in.
- C21  in  1: NOT. ACC ← ~BR_in.
- BR_in  in  16: operand from BR.
- ACC_out  out  16: accumulator register.
- ALUflags  out  4: {ZF, CF, OF, SF}. Bit 3 is ZF and bit 0 is SF. Registered.

## Operation
- Each rising edge with rst=0 executes the active control line. ACC and ALUflags update on the same edge.
- No line active: ACC and flags hold.
- Several lines active: the lowest-numbered line wins, in priority order C8 > C9 > C13 > C15 > C16 > C17 > C18 > C19 > C20 > C21.
- ZF = (result == 0). SF = result[15]. Both are computed on every executed operation.
- Add:
  - CF = carry out of bit 15.
  - OF = operands have the same sign and the result sign differs.
- Subtract:
  - CF = borrow, i.e. ACC < BR_in unsigned.
  - OF = operands have differing signs and the result sign differs from ACC.
- Multiply: CF = OF = 1 when the upper 16 bits of the 32-bit product are nonzero.
- Divide:
  - BR_in ≠ 0: CF = OF = 0.
  - BR_in = 0: ACC unchanged, OF = 1, CF = 0, and ZF/SF reflect the unchanged ACC.
- Shifts:
  - CF = last bit shifted out.
  - Shift amount 0: ACC unchanged, CF = 0.
  - OF = 0.
- Clear, AND, OR, NOT: CF = OF = 0. Clear therefore gives flags 4'b1000.
- All arithmetic wraps modulo 2^16.

## Timing
- rst=1 at a rising edge sets ACC_out = 16'h0000 and ALUflags = 4'b0000. Reset overrides every control line.
- Latency is 1 cycle: a control line sampled high at edge N yields the new ACC_out/ALUflags immediately after edge N.
- Operations issued back-to-back on consecutive cycles are each executed, using the ACC produced by the previous cycle.
- There is no handshake and no multi-cycle state. Multiply and divide are combinational within one cycle.
- Reset asserted in the same cycle as an operation: the reset wins and the operation is discarded.

## Configuration
- ALU_ACC_MULDIV_EN defined: multiply (C15) and divide (C16) are implemented as specified.
- ALU_ACC_MULDIV_EN undefined:
  - No multiplier or divider is synthesized.
  - C15/C16 act as no-ops: ACC and flags hold.
  - They keep their priority slots, so a lower-priority line active in the same cycle is still suppressed.

## Structure
- Shared package alu_acc_pkg contains:
  - the WIDTH default;
  - flag bit index constants ZF_BIT=3, CF_BIT=2, OF_BIT=1, SF_BIT=0;
  - an op enum produced by the priority encoder.
- One sub-module, alu_acc_core:
  - purely combinational;
  - inputs: op, ACC, BR_in; outputs: result and next flags.
  - The top level holds the priority encoder and the ACC/flag registers.

## Test plan
- Reset, then C8 → ACC_out=0000, flags 1000. Next, BR_in=1234 with C9 → 1234, flags 0000.
- Chained operations from ACC=1234:
  - C13 with BR_in=0033 → 1201.
  - C15 with BR_in=0003 → 3603.
  - C16 with BR_in=0002 → 1B01.
  - C17 with BR_in=0002 → 6C04.
  - C18 with BR_in=0001 → 3602, CF=0.
- Logic chain from ACC=3602:
  - C19 with BR_in=FF00 → 3600.
  - C20 with BR_in=00FF → 36FF.
  - C21 with BR_in=AAAA → 5555, flags 0000.
- Overflow: clear, add 7FFF, add 0001 → 8000, ZF=0, CF=0, OF=1, SF=1.
- Divide by zero: clear, add 0005, C16 with BR_in=0000 → ACC stays 0005, flags 0010.
- Priority and hold:
  - C8 and C9 asserted together → 0000.
  - No line active → ACC and flags unchanged.
  - rst during C9 → 0000, flags 0000.
